// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCORE = 2'd1,
        ST_MSG   = 2'd2
    } arb_state_t;

    typedef logic [1:0] digit_t;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] PAT_0 = 7'h40;
    localparam logic [6:0] PAT_1 = 7'h79;
    localparam logic [6:0] PAT_2 = 7'h24;
    localparam logic [6:0] PAT_3 = 7'h30;
    localparam logic [6:0] PAT_4 = 7'h19;
    localparam logic [6:0] PAT_5 = 7'h12;
    localparam logic [6:0] PAT_6 = 7'h02;
    localparam logic [6:0] PAT_7 = 7'h78;
    localparam logic [6:0] PAT_8 = 7'h00;
    localparam logic [6:0] PAT_9 = 7'h10;

    // Digit 3 is the leftmost position and lives in bits [27:21].
    function automatic logic [6:0] glyph_at(input logic [27:0] glyphs, input digit_t d);
        return glyphs[d*7 +: 7];
    endfunction

    function automatic logic [3:0] anode_for(input digit_t d);
        logic [3:0] onehot;
        onehot = 4'b0001 << d;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational decimal digit to active-low 7-segment pattern.
// Values above 9 decode to BLANK, which the top uses to suppress leading zeros.
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    always_comb begin
        case (value)
            4'd0:    pattern = PAT_0;
            4'd1:    pattern = PAT_1;
            4'd2:    pattern = PAT_2;
            4'd3:    pattern = PAT_3;
            4'd4:    pattern = PAT_4;
            4'd5:    pattern = PAT_5;
            4'd6:    pattern = PAT_6;
            4'd7:    pattern = PAT_7;
            4'd8:    pattern = PAT_8;
            4'd9:    pattern = PAT_9;
            default: pattern = BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Two-requester owner arbitration and digit multiplexing for the 4-digit display.
// Optional SEG_BLANK_EN inserts a blank cycle before every digit to suppress ghosting.
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int HOLD_SCANS = 16
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic        req_score,
    input  logic [3:0]  score_l,
    input  logic [3:0]  score_r,
    input  logic        req_msg,
    input  logic [27:0] msg_glyph,
    output logic        gnt_score,
    output logic        gnt_msg,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        scan_done
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_SCANS);

    arb_state_t  state, state_nx, last_owner, last_nx, grant, other;
    digit_t      digit, digit_nx;
    logic [7:0]  hold, hold_nx, hold_inc;
    logic [27:0] shadow, shadow_nx, score_glyph, new_glyph;
    logic [6:0]  seg_nx;
    logic [3:0]  an_nx;
    logic        done_nx, start, at_boundary, other_req, own_req;
    logic [3:0]  tens_l, ones_l, tens_r, ones_r;
`ifdef SEG_BLANK_EN
    logic        phase, phase_nx;
`endif

    // A tens value of 15 is out of range for the decoder and so renders blank.
    assign tens_l = (score_l >= 4'd10) ? 4'd1 : 4'd15;
    assign ones_l = (score_l >= 4'd10) ? score_l - 4'd10 : score_l;
    assign tens_r = (score_r >= 4'd10) ? 4'd1 : 4'd15;
    assign ones_r = (score_r >= 4'd10) ? score_r - 4'd10 : score_r;

    seg_bcd_decode u_dec_tl (.value(tens_l), .pattern(score_glyph[27:21]));
    seg_bcd_decode u_dec_ol (.value(ones_l), .pattern(score_glyph[20:14]));
    seg_bcd_decode u_dec_tr (.value(tens_r), .pattern(score_glyph[13:7]));
    seg_bcd_decode u_dec_or (.value(ones_r), .pattern(score_glyph[6:0]));

    assign other     = (state == ST_SCORE) ? ST_MSG : ST_SCORE;
    assign other_req = (state == ST_SCORE) ? req_msg : req_score;
    assign own_req   = (state == ST_SCORE) ? req_score : req_msg;
    assign hold_inc  = (hold >= HOLD_MAX) ? HOLD_MAX : hold + 8'd1;
`ifdef SEG_BLANK_EN
    assign at_boundary = !phase && (digit == 2'd0);
`else
    assign at_boundary = (digit == 2'd0);
`endif

    always_comb begin
        state_nx  = state;
        last_nx   = last_owner;
        digit_nx  = digit;
        hold_nx   = hold;
        shadow_nx = shadow;
        seg_nx    = BLANK;
        an_nx     = 4'hF;
        done_nx   = 1'b0;
        grant     = ST_IDLE;
        start     = 1'b0;
        new_glyph = msg_glyph;
`ifdef SEG_BLANK_EN
        phase_nx  = phase;
`endif
        if (state == ST_IDLE) begin
            hold_nx  = '0;
            digit_nx = 2'd3;
            if (req_score && req_msg) begin
                start = 1'b1;
                grant = (last_owner == ST_SCORE) ? ST_MSG : ST_SCORE;
            end else if (req_score) begin
                start = 1'b1;
                grant = ST_SCORE;
            end else if (req_msg) begin
                start = 1'b1;
                grant = ST_MSG;
            end
        end else if (at_boundary) begin
            if (hold_inc < HOLD_MAX) begin
                start   = 1'b1;
                grant   = state;
                hold_nx = hold_inc;
            end else if (other_req) begin
                start   = 1'b1;
                grant   = other;
                last_nx = state;
                hold_nx = '0;
            end else if (own_req) begin
                start   = 1'b1;
                grant   = state;
                hold_nx = hold_inc;
            end else begin
                state_nx = ST_IDLE;
                last_nx  = state;
                hold_nx  = '0;
                digit_nx = 2'd3;
            end
        end else begin
`ifdef SEG_BLANK_EN
            if (phase) begin
                phase_nx = 1'b0;
                seg_nx   = glyph_at(shadow, digit);
                an_nx    = anode_for(digit);
                done_nx  = (digit == 2'd0);
            end else begin
                phase_nx = 1'b1;
                digit_nx = digit - 2'd1;
            end
`else
            digit_nx = digit - 2'd1;
            seg_nx   = glyph_at(shadow, digit_nx);
            an_nx    = anode_for(digit_nx);
            done_nx  = (digit_nx == 2'd0);
`endif
        end

        // Every new scan latches the owner's glyphs so the scan cannot tear.
        new_glyph = (grant == ST_SCORE) ? score_glyph : msg_glyph;
        if (start) begin
            state_nx  = grant;
            digit_nx  = 2'd3;
            shadow_nx = new_glyph;
`ifdef SEG_BLANK_EN
            phase_nx  = 1'b1;
`else
            seg_nx    = new_glyph[27:21];
            an_nx     = anode_for(2'd3);
`endif
        end
    end

    always_ff @(posedge segclk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            last_owner <= ST_MSG;
            digit      <= 2'd3;
            hold       <= '0;
            shadow     <= '1;
            seg        <= BLANK;
            an         <= 4'hF;
            scan_done  <= 1'b0;
            gnt_score  <= 1'b0;
            gnt_msg    <= 1'b0;
        end else begin
            last_owner <= last_nx;
            digit      <= digit_nx;
            hold       <= hold_nx;
            shadow     <= shadow_nx;
            seg        <= seg_nx;
            an         <= an_nx;
            scan_done  <= done_nx;
            gnt_score  <= (state_nx == ST_SCORE);
            gnt_msg    <= (state_nx == ST_MSG);
        end
    end

`ifdef SEG_BLANK_EN
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) phase <= 1'b0;
        else     phase <= phase_nx;
    end
`endif

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with a scan-level reference model.
module tb_seg_scan_arbiter;

    localparam int H = 2;
    localparam logic [27:0] MSG1 = {7'h0C, 7'h08, 7'h47, 7'h06};
    localparam logic [27:0] MSG2 = {7'h12, 7'h21, 7'h2F, 7'h63};

    logic        segclk = 1'b0;
    logic        clr, req_score, req_msg;
    logic [3:0]  score_l, score_r;
    logic [27:0] msg_glyph;
    logic        gnt_score, gnt_msg, scan_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;
    bit run = 0;

    seg_scan_arbiter #(.HOLD_SCANS(H)) dut (
        .segclk(segclk), .clr(clr), .req_score(req_score), .score_l(score_l),
        .score_r(score_r), .req_msg(req_msg), .msg_glyph(msg_glyph),
        .gnt_score(gnt_score), .gnt_msg(gnt_msg), .seg(seg), .an(an),
        .scan_done(scan_done)
    );

    always #5 segclk = ~segclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=score 2=msg; pos 0 is the leftmost digit.
    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int m_owner = 0;
    int m_pos = 0;
    int m_scans = 0;
    int m_last = 2;
    int m_other;
    logic [6:0] m_frame [4];

    function automatic logic [6:0] tens_pat(input int v);
        return (v / 10 == 0) ? 7'h7F : pat[v / 10];
    endfunction

    function automatic bit wants(input int who);
        return (who == 1) ? req_score : req_msg;
    endfunction

    task automatic load_frame(input int who);
        if (who == 1) begin
            m_frame[0] = tens_pat(int'(score_l));
            m_frame[1] = pat[int'(score_l) % 10];
            m_frame[2] = tens_pat(int'(score_r));
            m_frame[3] = pat[int'(score_r) % 10];
        end else begin
            for (int i = 0; i < 4; i++) m_frame[i] = msg_glyph[(27 - 7*i) -: 7];
        end
    endtask

    always @(posedge segclk or posedge clr) begin
        if (clr) begin
            m_owner = 0; m_pos = 0; m_scans = 0; m_last = 2;
        end else if (m_owner == 0) begin
            if (req_score && req_msg) m_owner = (m_last == 1) ? 2 : 1;
            else if (req_score)       m_owner = 1;
            else if (req_msg)         m_owner = 2;
            if (m_owner != 0) begin
                m_scans = 0; m_pos = 0; load_frame(m_owner);
            end
        end else if (m_pos < 3) begin
            m_pos++;
        end else begin
            m_other = 3 - m_owner;
            m_scans = (m_scans + 1 > H) ? H : m_scans + 1;
            if (m_scans >= H) begin
                if (wants(m_other)) begin
                    m_last = m_owner; m_owner = m_other; m_scans = 0;
                end else if (!wants(m_owner)) begin
                    m_last = m_owner; m_owner = 0;
                end
            end
            m_pos = 0;
            if (m_owner != 0) load_frame(m_owner);
        end
    end

    always @(negedge segclk) begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        if (run) begin
            exp_an  = (m_owner != 0) ? ~(4'b1000 >> m_pos) : 4'hF;
            exp_seg = (m_owner != 0) ? m_frame[m_pos] : 7'h7F;
            check("seg", seg, exp_seg);
            check("an", an, exp_an);
            check("gnt_score", gnt_score, m_owner == 1);
            check("gnt_msg", gnt_msg, m_owner == 2);
            check("scan_done", scan_done, (m_owner != 0) && (m_pos == 3));
            check("gnt_excl", gnt_score & gnt_msg, 1'b0);
        end
    end

    task automatic tick();
        @(posedge segclk);
        #2;
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        report();
        $finish;
    end

    initial begin
        bit found;
        clr = 1'b1; req_score = 1'b0; req_msg = 1'b0;
        score_l = 4'd0; score_r = 4'd0; msg_glyph = MSG1;
        repeat (3) tick();
        clr = 1'b0; run = 1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_gnt", {gnt_score, gnt_msg}, 2'b00);
        repeat (20) tick();
        check("idle_an", an, 4'hF);

        // Score grant with 12 : 5, then message raised at cycle 1.
        score_l = 4'd12; score_r = 4'd5; req_score = 1'b1;
        tick();
        check("c0_gnt", gnt_score, 1'b1);
        check("c0_an", an, 4'b0111);
        check("c0_seg", seg, 7'h79);
        tick();
        check("c1_an", an, 4'b1011);
        check("c1_seg", seg, 7'h24);
        req_score = 1'b0; req_msg = 1'b1;
        tick();
        check("c2_an", an, 4'b1101);
        check("c2_seg", seg, 7'h7F);
        tick();
        check("c3_an", an, 4'b1110);
        check("c3_seg", seg, 7'h12);
        check("c3_done", scan_done, 1'b1);
        repeat (4) tick();
        check("c7_gnt", {gnt_score, gnt_msg}, 2'b10);
        tick();
        check("c8_gnt", {gnt_score, gnt_msg}, 2'b01);
        check("c8_seg", seg, 7'h0C);
        check("c8_an", an, 4'b0111);

        // Glyph change while digit 2 is shown must not tear the scan.
        tick();
        check("tear_d2", seg, 7'h08);
        msg_glyph = MSG2;
        tick();
        check("tear_d1", seg, 7'h47);
        tick();
        check("tear_d0", seg, 7'h06);
        tick();
        check("tear_new", seg, 7'h12);

        // Reset while digit 1 is shown.
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (an == 4'b1101) found = 1;
            else tick();
        end
        check("wait_d1", found, 1'b1);
        clr = 1'b1;
        #1;
        check("clr_an", an, 4'hF);
        check("clr_seg", seg, 7'h7F);
        check("clr_gnt", {gnt_score, gnt_msg}, 2'b00);
        tick();
        clr = 1'b0;
        tick();
        check("post_clr_gnt", gnt_msg, 1'b1);
        check("post_clr_an", an, 4'b0111);
        check("post_clr_seg", seg, 7'h12);

        // Ties: score wins first after reset, message wins the next one.
        req_msg = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("tie_idle", {gnt_score, gnt_msg}, 2'b00);
        req_score = 1'b1; req_msg = 1'b1;
        tick();
        check("tie1", {gnt_score, gnt_msg}, 2'b10);
        req_score = 1'b0; req_msg = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (!gnt_score) found = 1;
        end
        check("release_idle", found, 1'b1);
        check("release_an", an, 4'hF);
        req_score = 1'b1; req_msg = 1'b1;
        tick();
        check("tie2", {gnt_score, gnt_msg}, 2'b01);

        // Message drops as score keeps asking, then a few score pairs.
        req_msg = 1'b0;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin score_l = 4'd0;  score_r = 4'd9;  end
                1: begin score_l = 4'd15; score_r = 4'd10; end
                2: begin score_l = 4'd7;  score_r = 4'd0;  end
                default: begin score_l = 4'd9; score_r = 4'd15; end
            endcase
            repeat (8) tick();
        end
        req_score = 1'b0;
        repeat (16) tick();
        check("final_idle", {gnt_score, gnt_msg}, 2'b00);
        run = 0;
        report();
        $finish;
    end

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Shares the 4-digit 7-segment display between two requesters: the score source and the message source. It grants display ownership to one requester at a time, holds each grant for a minimum number of full scans, and multiplexes the owner's four glyphs onto `seg`/`an` one digit per `segclk` cycle. It sits between the game logic and the board pins and is the sole driver of the 7-segment display.

## Interface
- `HOLD_SCANS`, default 16: minimum number of completed full scans a grant is held before it can be released or preempted. Legal range is 1–255.
- `segclk`  in  1  digit-scan clock (same divided clock the display logic already uses).
- `clr`  in  1  reset, asynchronous, active-high.
- `req_score`  in  1  score source requests the display (level).
- `score_l`  in  4  left player score, binary 0–15.
- `score_r`  in  4  right player score, binary 0–15.
- `req_msg`  in  1  message source requests the display (level).
- `msg_glyph`  in  28  four active-low 7-bit patterns: [27:21] is the leftmost digit and [6:0] is the rightmost.
- `gnt_score`  out  1  score source owns the display.
- `gnt_msg`  out  1  message source owns the display.
- `seg`  out  7  segment cathodes, active-low.
- `an`  out  4  digit anodes, active-low; an[3] is the leftmost digit.
- `scan_done`  out  1  one-cycle pulse on the last digit of each full scan while granted.

## Operation
- **Arbiter FSM states:** IDLE, SCORE, MSG.
- **Reset values:** state=IDLE, seg=7'h7F, an=4'hF, gnt_*=0, scan_done=0, hold=0, digit=3, last_owner=MSG. As a result, the first tie after reset goes to score.
- **Decisions happen only at a scan boundary.** A scan boundary is every cycle in IDLE, or the cycle in which the rightmost digit (digit 0) is being driven.
- **From IDLE:**
  - Exactly one request is asserted: grant it.
  - Both requests are asserted: grant the requester that is not last_owner.
  - No request: stay in IDLE and drive blank outputs.
- **From owner X at a boundary:**
  - First compute hold' = min(hold+1, HOLD_SCANS).
  - If hold' < HOLD_SCANS: stay X; requests are ignored.
  - Else, if the other requester is asserted: switch to it, set last_owner=X, and clear hold.
  - Else, if X's request is still asserted: stay X.
  - Else: go to IDLE with blank outputs.
- **Shadow register (28 bits):** loaded with the owner's four glyphs at the boundary that starts each scan. Glyphs are never re-sampled mid-scan, which prevents tearing.
- **Score glyph formation:**
  - Left pair shows score_l as two decimal digits (tens, ones); right pair shows score_r the same way.
  - A leading tens digit of 0 is blanked (7'h7F). Example: score_l=3 displays as blank then "3".
  - Sub-module `seg_bcd_decode` converts 0–9 to active-low patterns.
- **Scan order:** digit 3→2→1→0 (left to right), one digit per cycle.
  - an is one-hot-low for the active digit; seg carries the shadow glyph for that digit.
- **Mutual exclusion:** gnt_score and gnt_msg are never both high.
- **scan_done:** high only in the digit-0 cycle of a granted scan.

## Timing
- All outputs are registered on posedge segclk.
- **Grant latency:** a request raised while in IDLE appears on gnt_* at the next edge. The leftmost digit of the new owner is driven on that same edge.
- A full scan takes 4 cycles (8 cycles with SEG_BLANK_EN).
- **Minimum grant duration:** 4·HOLD_SCANS cycles (8·HOLD_SCANS with SEG_BLANK_EN).
- A request dropped mid-scan has no effect until the boundary; the scan always completes.
- **Simultaneous events:**
  - If X drops its request and the other requester raises its request in the same boundary cycle with the hold met, the grant switches directly (no IDLE cycle).
  - If both requests drop at a met boundary, the FSM goes to IDLE.
- **Reset mid-scan:** outputs blank immediately and asynchronously; the next grant starts at digit 3.
- The hold counter saturates and does not wrap.

## Configuration
- **`SEG_BLANK_EN`**
  - Defined: a blank cycle (an=4'hF, seg=7'h7F) precedes every digit, to suppress ghosting. scan_done coincides with the digit-0 display cycle. A scan boundary is the digit-0 display cycle.
  - Undefined: no blank cycles; 4-cycle scans.

## Structure
- **Shared package `seg_pkg`:**
  - Arbiter state enum.
  - BLANK=7'h7F.
  - Digit-pattern constants 0–9.
  - Digit index type (2 bits).
- **Sub-module `seg_bcd_decode`:** combinational, 4-bit value in, 7-bit active-low pattern out; inputs outside 0–9 produce BLANK.
- All state lives in `seg_scan_arbiter`: FSM, hold counter, digit counter, shadow register, last_owner.

## Test plan
- Reset, no requests for 20 cycles -> an=4'hF, seg=7'h7F, gnt=00 throughout.
- req_score=1, score_l=12, score_r=5 -> gnt_score next edge; an cycles 0111,1011,1101,1110 with seg=pattern(1), pattern(2), BLANK, pattern(5); scan_done every 4th cycle.
- HOLD_SCANS=2, score granted, req_msg raised at cycle 1 -> gnt_msg rises exactly at cycle 8; first msg digit seg=msg_glyph[27:21].
- Both requests raised together from reset, then again after score releases to IDLE -> score wins the first tie, msg wins the second.
- msg_glyph changed in the cycle when digit 2 is displayed -> digits 1 and 0 of that scan still show the old glyphs; the new glyphs appear from the next scan.
- clr pulsed while digit 1 is displayed -> outputs blank the same cycle; gnt=00; after release with req_msg=1 the scan restarts at an=0111; with SEG_BLANK_EN, an=1111 on alternate cycles.
